// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants for the data-memory responder: MMIO window
//               layout, register offsets and STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Default location of the 16-byte MMIO window
    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h8000_0000;
    localparam logic [31:0] MMIO_WINDOW_BYTES = 32'd16;

    // Byte offsets of the MMIO registers inside the window
    localparam logic [3:0] MMIO_OFF_MTIME_LO = 4'h0;
    localparam logic [3:0] MMIO_OFF_MTIME_HI = 4'h4;
    localparam logic [3:0] MMIO_OFF_TOHOST   = 4'h8;
    localparam logic [3:0] MMIO_OFF_STATUS   = 4'hC;

    // STATUS register bit positions
    localparam int STATUS_FAULT_BIT = 0;
    localparam int STATUS_HALT_BIT  = 1;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/mtime_counter.sv
`default_nettype none
// ============================================================================
// Module      : mtime_counter
// Description : Free-running 64-bit machine timer with a HI-word shadow that
//               is captured on request, so a LO read followed by a HI read
//               yields a consistent 64-bit sample.
//               Present only when DMEM_RESPONDER_MTIME_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef DMEM_RESPONDER_MTIME_EN
module mtime_counter (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        capture_hi,
    output logic [31:0] mtime_lo,
    output logic [31:0] hi_shadow
);

    logic [63:0] count;

    // Counter increments every cycle and wraps naturally at 2^64
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= 64'd0;
        end else begin
            count <= count + 64'd1;
        end
    end

    // Shadow samples the upper word as it was during the LO read cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hi_shadow <= 32'd0;
        end else if (capture_hi) begin
            hi_shadow <= count[63:32];
        end
    end

    assign mtime_lo = count[31:0];

endmodule : mtime_counter
`endif
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-port data memory with same-cycle reads, a small MMIO
//               window (mtime, TOHOST, STATUS), access-fault detection and a
//               sticky halt raised by a TOHOST write.
//               Optional macro DMEM_RESPONDER_MTIME_EN adds the mtime timer;
//               without it the MTIME offsets are unmapped.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = DEFAULT_MMIO_BASE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_halt,
    output logic [31:0] o_tohost
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]      ram [DEPTH_WORDS];
    logic [31:0]      mmio_off;
    logic [IDX_W-1:0] word_idx;
    logic             ram_hit;
    logic             mmio_hit;
    logic             aligned;
    logic             mapped;
    logic             tohost_hit;
    logic             status_hit;
    logic             fault;
    logic             wr_ok;
    logic             sticky_fault;
    logic             halt;
    logic [31:0]      tohost;
    logic [31:0]      rdata;

    // Address decode; the subtraction form keeps the window check correct
    // for any base without needing a 33-bit upper bound.
    assign mmio_off   = i_addr - MMIO_BASE;
    assign ram_hit    = {1'b0, i_addr} < RAM_BYTES;
    assign mmio_hit   = mmio_off < MMIO_WINDOW_BYTES;
    assign word_idx   = i_addr[IDX_W+1:2];
    assign aligned    = (i_addr[1:0] == 2'b00);
    assign tohost_hit = mmio_hit && (mmio_off[3:2] == MMIO_OFF_TOHOST[3:2]);
    assign status_hit = mmio_hit && (mmio_off[3:2] == MMIO_OFF_STATUS[3:2]);

`ifdef DMEM_RESPONDER_MTIME_EN
    logic        lo_hit;
    logic        hi_hit;
    logic        capture_hi;
    logic [31:0] mtime_lo;
    logic [31:0] hi_shadow;

    assign lo_hit     = mmio_hit && (mmio_off[3:2] == MMIO_OFF_MTIME_LO[3:2]);
    assign hi_hit     = mmio_hit && (mmio_off[3:2] == MMIO_OFF_MTIME_HI[3:2]);
    assign mapped     = ram_hit || mmio_hit;
    assign capture_hi = i_ren && lo_hit && !fault;

    mtime_counter u_mtime (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .capture_hi (capture_hi),
        .mtime_lo   (mtime_lo),
        .hi_shadow  (hi_shadow)
    );
`else
    assign mapped = ram_hit || tohost_hit || status_hit;
`endif

    // Faults are suppressed while reset is held so outputs stay quiet
    assign fault = i_rst_n && (i_ren || i_wen) && (!aligned || !mapped);

    // Only clean, non-halted writes outside reset have side effects
    assign wr_ok = i_rst_n && i_wen && !fault && !halt;

    // Read mux: RAM or MMIO register, zero for idle, fault or reset
    always_comb begin
        rdata = 32'd0;
        if (i_rst_n && i_ren && !fault) begin
            if (ram_hit) begin
                rdata = ram[word_idx];
            end else if (status_hit) begin
                rdata[STATUS_FAULT_BIT] = sticky_fault;
                rdata[STATUS_HALT_BIT]  = halt;
`ifdef DMEM_RESPONDER_MTIME_EN
            end else if (lo_hit) begin
                rdata = mtime_lo;
            end else if (hi_hit) begin
                rdata = hi_shadow;
`endif
            end
        end
    end

    // RAM array is not reset; it keeps its contents across reset
    always_ff @(posedge i_clk) begin
        if (wr_ok && ram_hit) begin
            ram[word_idx] <= i_wdata;
        end
    end

    // Control registers: TOHOST/halt capture and the sticky fault flag,
    // where a fault in the same cycle wins over a STATUS clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tohost       <= 32'd0;
            halt         <= 1'b0;
            sticky_fault <= 1'b0;
        end else begin
            if (wr_ok && tohost_hit) begin
                tohost <= i_wdata;
                halt   <= 1'b1;
            end
            if (fault) begin
                sticky_fault <= 1'b1;
            end else if (wr_ok && status_hit && i_wdata[STATUS_FAULT_BIT]) begin
                sticky_fault <= 1'b0;
            end
        end
    end

    assign o_rdata  = rdata;
    assign o_fault  = fault;
    assign o_halt   = halt;
    assign o_tohost = tohost;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder: directed scenarios
//               plus randomized traffic checked against a behavioural model.
//               Honours DMEM_RESPONDER_MTIME_EN for the mtime scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h8000_0000;
`ifdef DMEM_RESPONDER_MTIME_EN
    localparam bit MTIME = 1'b1;
`else
    localparam bit MTIME = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        ren   = 1'b0;
    logic        wen   = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        fault;
    logic        halt;
    logic [31:0] tohost;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .MMIO_BASE   (BASE)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_ren    (ren),
        .i_wen    (wen),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .o_rdata  (rdata),
        .o_fault  (fault),
        .o_halt   (halt),
        .o_tohost (tohost)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state
    logic [31:0] m_ram [DEPTH];
    bit          m_halt;
    bit          m_sticky;
    logic [31:0] m_tohost;

    logic [31:0] last_rd;
    logic        last_flt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // kind: 0 unmapped, 1 RAM, 2 MMIO; word = word index within region
    function automatic void classify(input logic [31:0] a, output int kind, output int word);
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(BASE);
        kind = 0;
        word = 0;
        if (ua < longint'(DEPTH) * 4) begin
            kind = 1;
            word = int'(ua / 4);
        end else if (ua >= ub && ua < ub + 16) begin
            kind = 2;
            word = int'((ua - ub) / 4);
        end
    endfunction

    function automatic void predict(input bit r, input bit w, input logic [31:0] a,
                                    output logic [31:0] rd, output bit flt, output bit dc);
        int kind, word;
        bit mapd;
        classify(a, kind, word);
        mapd = (kind == 1) || (kind == 2 && (word >= 2 || MTIME));
        flt  = (r || w) && ((a % 4) != 0 || !mapd);
        rd   = 32'd0;
        dc   = 1'b0;
        if (r && !flt) begin
            if (kind == 1)      rd = m_ram[word];
            else if (word == 3) rd = {30'd0, m_halt, m_sticky};
            else if (word < 2)  dc = 1'b1;
        end
    endfunction

    function automatic void commit(input bit w, input logic [31:0] a, input logic [31:0] wd,
                                   input bit flt);
        int kind, word;
        classify(a, kind, word);
        if (w && !flt && !m_halt) begin
            if (kind == 1)                  m_ram[word] = wd;
            else if (word == 2)             begin m_tohost = wd; m_halt = 1'b1; end
            else if (word == 3 && wd[0])    m_sticky = 1'b0;
        end
        if (flt) m_sticky = 1'b1;
    endfunction

    task automatic do_op(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input string tag);
        logic [31:0] erd;
        bit          eflt, dc;
        @(negedge clk);
        ren = r; wen = w; addr = a; wdata = wd;
        #1;
        predict(r, w, a, erd, eflt, dc);
        check({tag, "_fault"}, {31'd0, fault}, {31'd0, eflt});
        if (!dc) check({tag, "_rdata"}, rdata, erd);
        last_rd  = rdata;
        last_flt = fault;
        @(posedge clk);
        commit(w, a, wd, eflt);
        #1;
        check({tag, "_halt"}, {31'd0, halt}, {31'd0, m_halt});
        check({tag, "_tohost"}, tohost, m_tohost);
    endtask

    function automatic logic [31:0] rand_addr(input bit allow_tohost);
        int unsigned sel = $urandom_range(0, 9);
        int unsigned off;
        if (sel <= 4) return 32'($urandom_range(0, DEPTH - 1)) * 4;
        if (sel == 5) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        if (sel <= 7) begin
            off = $urandom_range(0, 15);
            if (!allow_tohost && off == 8) off = 12;
            return BASE + 32'(off);
        end
        if (sel == 8) return 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
        return ($urandom_range(0, 1) != 0) ? BASE + 32'd16 : BASE - 32'd4;
    endfunction

    task automatic random_ops(input int n, input bit allow_tohost, input string tag);
        for (int i = 0; i < n; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rand_addr(allow_tohost), $urandom, tag);
        end
    endtask

    initial begin
        logic [31:0] prev;
        m_halt   = 1'b0;
        m_sticky = 1'b0;
        m_tohost = 32'd0;

        // Outputs held quiet during reset even with an active faulting request
        ren = 1'b1; wen = 1'b1; addr = 32'h3; wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rdata", rdata, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_tohost", tohost, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; ren = 1'b0; wen = 1'b0;

        for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b1, 32'(i * 4), $urandom, "init");

        // Write then read back
        do_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, "w33");
        do_op(1'b1, 1'b0, 32'h10, 32'd0, "r33");
        check("req33_data", last_rd, 32'hDEAD_BEEF);

        // Simultaneous read+write returns old data
        do_op(1'b0, 1'b1, 32'h20, 32'hAAAA_AAAA, "w34");
        do_op(1'b1, 1'b1, 32'h20, 32'h1122_3344, "rw34");
        check("req34_old", last_rd, 32'hAAAA_AAAA);
        do_op(1'b1, 1'b0, 32'h20, 32'd0, "r34");
        check("req34_new", last_rd, 32'h1122_3344);

        // Misaligned write faults, sets sticky, STATUS write clears it
        do_op(1'b0, 1'b1, 32'h13, 32'h5555_5555, "w35");
        check("req35_fault", {31'd0, last_flt}, 32'd1);
        do_op(1'b1, 1'b0, 32'h10, 32'd0, "r35");
        check("req35_ram", last_rd, 32'hDEAD_BEEF);
        do_op(1'b1, 1'b0, BASE + 32'hC, 32'd0, "st35a");
        check("req35_sticky", last_rd, 32'd1);
        do_op(1'b0, 1'b1, BASE + 32'hC, 32'd1, "clr35");
        do_op(1'b1, 1'b0, BASE + 32'hC, 32'd0, "st35b");
        check("req35_clear", last_rd, 32'd0);

`ifdef DMEM_RESPONDER_MTIME_EN
        // Shadow must capture the HI word before the LO carry propagates
        @(negedge clk);
        ren = 1'b1; wen = 1'b0; addr = BASE;
        force dut.u_mtime.count = 64'h0000_0000_FFFF_FFFF;
        #1;
        check("mtime_lo", rdata, 32'hFFFF_FFFF);
        check("mtime_lo_fault", {31'd0, fault}, 32'd0);
        release dut.u_mtime.count;
        @(posedge clk);
        @(negedge clk);
        addr = BASE + 32'h4;
        #1;
        check("mtime_hi", rdata, 32'd0);
        @(posedge clk);
`else
        do_op(1'b1, 1'b0, BASE, 32'd0, "mtlo");
        check("mtlo_unmapped", {31'd0, last_flt}, 32'd1);
        do_op(1'b0, 1'b1, BASE + 32'h4, 32'h1, "mthi");
        check("mthi_unmapped", {31'd0, last_flt}, 32'd1);
`endif

        random_ops(400, 1'b0, "rnd");

        // TOHOST write halts; later writes are ignored
        do_op(1'b0, 1'b1, BASE + 32'h8, 32'h1, "th37");
        check("req37_halt", {31'd0, halt}, 32'd1);
        check("req37_tohost", tohost, 32'h1);
        prev = m_ram[0];
        do_op(1'b0, 1'b1, 32'h0, 32'h5, "w37");
        do_op(1'b1, 1'b0, 32'h0, 32'd0, "r37");
        check("req37_ram0", last_rd, prev);
        random_ops(150, 1'b1, "rndh");

        // Reset during a pending write discards it; RAM keeps prior data
        prev = m_ram[16];
        @(negedge clk);
        ren = 1'b1; wen = 1'b1; addr = 32'h40; wdata = ~prev;
        #2 rst_n = 1'b0;
        #1;
        check("req38_rdata", rdata, 32'd0);
        check("req38_fault", {31'd0, fault}, 32'd0);
        check("req38_halt", {31'd0, halt}, 32'd0);
        check("req38_tohost", tohost, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; ren = 1'b0; wen = 1'b0;
        m_halt = 1'b0; m_sticky = 1'b0; m_tohost = 32'd0;
        do_op(1'b1, 1'b0, 32'h40, 32'd0, "r38");
        check("req38_ram", last_rd, prev);
        do_op(1'b1, 1'b0, BASE + 32'hC, 32'd0, "st38");
        check("req38_status", last_rd, 32'd0);

        random_ops(150, 1'b1, "rndr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
